// File: rtl/ps2_teclado_ctrl.sv
// Host-side PS/2 keyboard controller: reset/BAT initialisation, LED updates,
// host-to-device framing on the open-drain lines, and gating of the rx stream.
module ps2_teclado_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int BIT_TIMEOUT    = 100000,
  parameter int ACK_TIMEOUT    = 1000000,
  parameter int BAT_TIMEOUT    = 50000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] rx_code,
  input  logic       rx_valid,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       led_busy,
  output logic       init_done,
  output logic       rx_gate,
  output logic       error
);

  localparam int TX_MAX  = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
  localparam int TW      = $clog2(TX_MAX + 1);
  localparam int RSP_MAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
  localparam int RW      = $clog2(RSP_MAX + 1);
  localparam int CW      = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_INIT_TX, S_INIT_ACK, S_WAIT_BAT, S_READY,
    S_LED_CMD, S_LED_ACK1, S_LED_DATA, S_LED_ACK2, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_INHIBIT, TX_REQ, TX_SHIFT, TX_ACKBIT
  } tx_state_t;

  logic [1:0] clk_sync_reg, data_sync_reg;
  logic       clk_prev_reg;
  logic       clk_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_in};
      data_sync_reg <= {data_sync_reg[0], ps2_data_in};
      clk_prev_reg  <= clk_sync_reg[1];
    end
  end

  assign clk_fall = clk_prev_reg & ~clk_sync_reg[1];

  state_t          state_reg, state_next;
  logic [CW-1:0]   retry_reg, retry_next;
  logic            busy_reg, busy_next;
  logic [2:0]      led_reg, led_next;
  logic [RW-1:0]   rsp_cnt_reg, rsp_cnt_next;

  tx_state_t       tx_state_reg, tx_state_next;
  logic [TW-1:0]   tx_cnt_reg, tx_cnt_next;
  logic [3:0]      edge_cnt_reg, edge_cnt_next;
  logic [8:0]      shift_reg, shift_next;
  logic            data_oe_reg, data_oe_next;
  logic            tx_ok, tx_fail, tx_go;
  logic [7:0]      tx_byte;

  assign tx_go = (state_reg == S_INIT_TX) || (state_reg == S_LED_CMD) || (state_reg == S_LED_DATA);

  always_comb begin
    tx_byte = 8'hFF;
    if (state_reg == S_LED_CMD)  tx_byte = 8'hED;
    if (state_reg == S_LED_DATA) tx_byte = {5'b0, led_reg};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      edge_cnt_reg <= '0;
      shift_reg    <= '0;
      data_oe_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      edge_cnt_reg <= edge_cnt_next;
      shift_reg    <= shift_next;
      data_oe_reg  <= data_oe_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    edge_cnt_next = edge_cnt_reg;
    shift_next    = shift_reg;
    data_oe_next  = data_oe_reg;
    tx_ok         = 1'b0;
    tx_fail       = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        data_oe_next = 1'b0;
        if (tx_go) begin
          tx_state_next = TX_INHIBIT;
          tx_cnt_next   = '0;
          shift_next    = {~^tx_byte, tx_byte};
        end
      end
      TX_INHIBIT: begin
        if (tx_cnt_reg >= TW'(INHIBIT_CYCLES - 1)) begin
          tx_state_next = TX_REQ;
          tx_cnt_next   = '0;
          data_oe_next  = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_REQ, TX_SHIFT, TX_ACKBIT: begin
        if (clk_fall) begin
          tx_cnt_next = '0;
          if (tx_state_reg == TX_REQ) begin
            data_oe_next  = ~shift_reg[0];
            shift_next    = shift_reg >> 1;
            edge_cnt_next = 4'd1;
            tx_state_next = TX_SHIFT;
          end else if (tx_state_reg == TX_SHIFT) begin
            edge_cnt_next = edge_cnt_reg + 4'd1;
            // Edge 10 releases data as the stop bit; the device then owns it.
            if (edge_cnt_reg == 4'd9) begin
              data_oe_next  = 1'b0;
              tx_state_next = TX_ACKBIT;
            end else begin
              data_oe_next = ~shift_reg[0];
              shift_next   = shift_reg >> 1;
            end
          end else begin
            data_oe_next  = 1'b0;
            tx_state_next = TX_IDLE;
            tx_ok         = ~data_sync_reg[1];
            tx_fail       = data_sync_reg[1];
          end
        end else if (tx_cnt_reg >= TW'(BIT_TIMEOUT - 1)) begin
          data_oe_next  = 1'b0;
          tx_state_next = TX_IDLE;
          tx_fail       = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_INIT_TX;
      retry_reg   <= '0;
      busy_reg    <= 1'b0;
      led_reg     <= '0;
      rsp_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      retry_reg   <= retry_next;
      busy_reg    <= busy_next;
      led_reg     <= led_next;
      rsp_cnt_reg <= rsp_cnt_next;
    end
  end

  logic init_phase, can_retry, ack_to, bat_to, rsp_fail;

  assign init_phase = (state_reg == S_INIT_TX) || (state_reg == S_INIT_ACK) || (state_reg == S_WAIT_BAT);
  assign can_retry  = retry_reg < CW'(MAX_RETRY - 1);
  assign ack_to     = rsp_cnt_reg >= RW'(ACK_TIMEOUT - 1);
  assign bat_to     = rsp_cnt_reg >= RW'(BAT_TIMEOUT - 1);
  assign rsp_fail   = (rx_valid && rx_code == 8'hFE) || ack_to;

  always_comb begin
    state_next   = state_reg;
    retry_next   = retry_reg;
    busy_next    = busy_reg;
    led_next     = led_reg;
    rsp_cnt_next = (rsp_cnt_reg == '1) ? rsp_cnt_reg : rsp_cnt_reg + 1'b1;
    if (init_phase && led_req) busy_next = 1'b1;
    case (state_reg)
      S_INIT_TX, S_LED_CMD, S_LED_DATA: begin
        if (tx_ok) begin
          state_next = (state_reg == S_INIT_TX) ? S_INIT_ACK :
                       (state_reg == S_LED_CMD) ? S_LED_ACK1 : S_LED_ACK2;
        end else if (tx_fail) begin
          if (can_retry) retry_next = retry_reg + 1'b1;
          else           state_next = S_ERROR;
        end
      end
      S_INIT_ACK, S_LED_ACK1, S_LED_ACK2: begin
        if (rx_valid && rx_code == 8'hFA) begin
          retry_next = '0;
          state_next = (state_reg == S_INIT_ACK) ? S_WAIT_BAT :
                       (state_reg == S_LED_ACK1) ? S_LED_DATA : S_READY;
          if (state_reg == S_LED_ACK2) busy_next = 1'b0;
        end else if (rsp_fail) begin
          if (can_retry) begin
            retry_next = retry_reg + 1'b1;
            state_next = (state_reg == S_INIT_ACK) ? S_INIT_TX :
                         (state_reg == S_LED_ACK1) ? S_LED_CMD : S_LED_DATA;
          end else begin
            state_next = S_ERROR;
          end
        end
      end
      S_WAIT_BAT: begin
        if (rx_valid && rx_code == 8'hAA)                 state_next = S_READY;
        else if ((rx_valid && rx_code == 8'hFC) || bat_to) state_next = S_ERROR;
      end
      S_READY: begin
        // A request left pending during init is taken on the first READY cycle.
        if (busy_reg || led_req) begin
          led_next   = led_val;
          busy_next  = 1'b1;
          state_next = S_LED_CMD;
        end
      end
      default: begin
        state_next = S_ERROR;
        busy_next  = 1'b0;
      end
    endcase
    if (state_next != state_reg) rsp_cnt_next = '0;
  end

  assign ps2_clk_oe  = (tx_state_reg == TX_INHIBIT);
  assign ps2_data_oe = data_oe_reg;
  assign led_busy    = busy_reg | (led_req & init_phase);
  assign init_done   = (state_reg == S_READY) || (state_reg == S_LED_CMD) || (state_reg == S_LED_ACK1) ||
                       (state_reg == S_LED_DATA) || (state_reg == S_LED_ACK2);
  assign rx_gate     = (state_reg == S_READY) && !busy_reg;
  assign error       = (state_reg == S_ERROR);

endmodule

// File: tb/tb_ps2_teclado_ctrl.sv
// Directed bench for ps2_teclado_ctrl: a simple PS/2 device model clocks
// host frames, returns the ACK bit and injects response codes on rx_code.
module tb_ps2_teclado_ctrl;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_data_in = 1'b1;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] rx_code = 8'h00;
  logic       rx_valid = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       led_busy, init_done, rx_gate, error;

  int checks = 0;
  int errors = 0;

  ps2_teclado_ctrl #(
    .INHIBIT_CYCLES(5000),
    .BIT_TIMEOUT(1000),
    .ACK_TIMEOUT(200),
    .BAT_TIMEOUT(3000),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .rx_code(rx_code),
    .rx_valid(rx_valid),
    .led_req(led_req),
    .led_val(led_val),
    .led_busy(led_busy),
    .init_done(init_done),
    .rx_gate(rx_gate),
    .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  // Device side of one host-to-device frame; stops early after falling edge stop_edge.
  task automatic dev_frame(input int stop_edge, input bit ack_ok, output logic [7:0] b,
                           output logic par, output logic stp, output int inhibit);
    int n;
    b = 8'h00; par = 1'b0; stp = 1'b0; inhibit = 0; n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 30000) begin @(negedge clk); n++; end
    if (ps2_clk_oe !== 1'b1) begin
      checks++; errors++;
      $display("FAIL frame_wait: clk_oe=%b required 1 within 30000 cycles", ps2_clk_oe);
      return;
    end
    while (ps2_clk_oe === 1'b1 && inhibit < 20000) begin @(negedge clk); inhibit++; end
    checks++;
    if (ps2_data_oe !== 1'b1) begin
      errors++;
      $display("FAIL start_bit: data_oe=%b required 1", ps2_data_oe);
    end
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        ps2_data_in = ack_ok ? 1'b0 : 1'b1;
        repeat (2) @(negedge clk);
      end
      ps2_clk_in = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == stop_edge) return;
      ps2_clk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 8)       b   = {~ps2_data_oe, b[7:1]};
      else if (k == 9)  par = ~ps2_data_oe;
      else if (k == 10) stp = ~ps2_data_oe;
    end
    ps2_data_in = 1'b1;
    $display("frame byte=%02h parity=%b stop=%b inhibit=%0d", b, par, stp, inhibit);
  endtask

  task automatic send_rx(input logic [7:0] code);
    @(negedge clk);
    rx_code = code; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    $display("rx code=%02h", code);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, led_busy, init_done, rx_gate, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000",
               {ps2_clk_oe, ps2_data_oe, led_busy, init_done, rx_gate, error});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_power_up();
    logic [7:0] b; logic p, s; int inh;
    dev_frame(0, 1'b1, b, p, s, inh);
    checks++;
    if (b !== 8'hFF || p !== 1'b1 || s !== 1'b1) begin
      errors++; $display("FAIL pu_frame: got %02h p%b s%b required ff p1 s1", b, p, s);
    end
    checks++;
    if (inh !== 5000) begin errors++; $display("FAIL pu_inhibit: got %0d required 5000", inh); end
    send_rx(8'hFA);
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL pu_wait_bat: init_done=%b required 0", init_done); end
    send_rx(8'hAA);
    @(negedge clk);
    checks++;
    if ({init_done, rx_gate, error} !== 3'b110) begin
      errors++; $display("FAIL pu_ready: done/gate/err=%b required 110", {init_done, rx_gate, error});
    end
  endtask

  task automatic test_led_update();
    logic [7:0] b; logic p, s; int inh;
    @(negedge clk);
    led_req = 1'b1; led_val = 3'b101;
    @(negedge clk);
    led_req = 1'b0;
    checks++;
    if ({led_busy, rx_gate, init_done} !== 3'b101) begin
      errors++; $display("FAIL led_accept: busy/gate/done=%b required 101", {led_busy, rx_gate, init_done});
    end
    dev_frame(0, 1'b1, b, p, s, inh);
    checks++;
    if (b !== 8'hED || p !== ~^8'hED || s !== 1'b1) begin
      errors++; $display("FAIL led_cmd_frame: got %02h p%b s%b required ed p%b s1", b, p, s, ~^8'hED);
    end
    send_rx(8'hFA);
    dev_frame(0, 1'b1, b, p, s, inh);
    checks++;
    if (b !== 8'h05 || p !== 1'b1 || s !== 1'b1) begin
      errors++; $display("FAIL led_data_frame: got %02h p%b s%b required 05 p1 s1", b, p, s);
    end
    checks++;
    if ({led_busy, rx_gate} !== 2'b10) begin
      errors++; $display("FAIL led_mid: busy/gate=%b required 10", {led_busy, rx_gate});
    end
    send_rx(8'hFA);
    @(negedge clk);
    checks++;
    if ({led_busy, rx_gate, init_done} !== 3'b011) begin
      errors++; $display("FAIL led_done: busy/gate/done=%b required 011", {led_busy, rx_gate, init_done});
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] b; logic p, s; int inh;
    @(negedge clk);
    led_req = 1'b1; led_val = 3'b011;
    @(negedge clk);
    led_req = 1'b0;
    dev_frame(5, 1'b1, b, p, s, inh);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
      errors++; $display("FAIL mid_pre: clk_oe/data_oe=%b required 01", {ps2_clk_oe, ps2_data_oe});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, led_busy, init_done} !== 4'b0000) begin
      errors++; $display("FAIL mid_release: oe/busy/done=%b required 0000",
                         {ps2_clk_oe, ps2_data_oe, led_busy, init_done});
    end
    ps2_clk_in = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_resend_and_early();
    logic [7:0] b; logic p, s; int inh;
    dev_frame(0, 1'b1, b, p, s, inh);
    checks++;
    if (b !== 8'hFF) begin errors++; $display("FAIL resend_first: got %02h required ff", b); end
    send_rx(8'hFE);
    dev_frame(0, 1'b1, b, p, s, inh);
    checks++;
    if (b !== 8'hFF || p !== 1'b1) begin errors++; $display("FAIL resend_second: got %02h p%b required ff p1", b, p); end
    send_rx(8'hFA);
    @(negedge clk);
    led_req = 1'b1; led_val = 3'b010;
    #1;
    checks++;
    if (led_busy !== 1'b1) begin errors++; $display("FAIL early_busy: led_busy=%b required 1", led_busy); end
    @(negedge clk);
    led_req = 1'b0;
    checks++;
    if ({led_busy, init_done} !== 2'b10) begin
      errors++; $display("FAIL early_pending: busy/done=%b required 10", {led_busy, init_done});
    end
    send_rx(8'hAA);
    dev_frame(0, 1'b1, b, p, s, inh);
    checks++;
    if (b !== 8'hED) begin errors++; $display("FAIL early_cmd: got %02h required ed (no third ff)", b); end
    send_rx(8'hFA);
    dev_frame(0, 1'b1, b, p, s, inh);
    checks++;
    if (b !== 8'h02 || p !== 1'b0) begin errors++; $display("FAIL early_data: got %02h p%b required 02 p0", b, p); end
    send_rx(8'hFA);
    @(negedge clk);
    checks++;
    if ({led_busy, rx_gate, init_done, error} !== 4'b0110) begin
      errors++; $display("FAIL early_done: busy/gate/done/err=%b required 0110",
                         {led_busy, rx_gate, init_done, error});
    end
  endtask

  task automatic test_retry_exhaust();
    logic [7:0] b; logic p, s; int inh;
    bit seen;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dev_frame(0, 1'b1, b, p, s, inh);
      checks++;
      if (b !== 8'hFF) begin errors++; $display("FAIL exhaust_frame%0d: got %02h required ff", i, b); end
    end
    repeat (300) @(negedge clk);
    checks++;
    if ({error, ps2_clk_oe, ps2_data_oe, init_done} !== 4'b1000) begin
      errors++; $display("FAIL exhaust_error: err/clk_oe/data_oe/done=%b required 1000",
                         {error, ps2_clk_oe, ps2_data_oe, init_done});
    end
    seen = 1'b0;
    repeat (6000) begin @(negedge clk); if (ps2_clk_oe === 1'b1) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL exhaust_no_fourth: clk_oe pulsed, required idle"); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_led_update();
    test_mid_frame_reset();
    test_resend_and_early();
    test_retry_exhaust();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
